// File: rtl/counter_arbiter_if.sv
// counter_arbiter_if: host/local-requester bus for counter_arbiter.
//   master modport (host side): drives the trig_* pulses and the local
//     request loc_req/loc_op; observes loc_ack, count, pend_up, pend_down,
//     busy and overflow.
//   slave modport (counter_arbiter): the mirror image.
interface counter_arbiter_if #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned PEND_W = 4
) ();
   logic              trig_reset;
   logic              trig_up;
   logic              trig_down;
   logic              loc_req;
   logic [1:0]        loc_op;
   logic              loc_ack;
   logic [WIDTH-1:0]  count;
   logic [PEND_W-1:0] pend_up;
   logic [PEND_W-1:0] pend_down;
   logic              busy;
   logic              overflow;

   modport master (
      output trig_reset, trig_up, trig_down, loc_req, loc_op,
      input  loc_ack, count, pend_up, pend_down, busy, overflow
   );

   modport slave (
      input  trig_reset, trig_up, trig_down, loc_req, loc_op,
      output loc_ack, count, pend_up, pend_down, busy, overflow
   );
endinterface

// File: rtl/counter_arbiter.sv
// counter_arbiter: up/down counter shared by a host (trigger pulses that are
// queued in pend_up/pend_down) and a local requester (loc_req/loc_op with a
// loc_ack handshake). A two-state FSM picks one source round-robin in IDLE
// (UP -> DOWN -> LOC) and applies that single op in EXEC.
//
// Ports:
//   clk1   - clock, rising edge
//   reset  - synchronous, active-high; has priority over bus.trig_reset
//   bus    - counter_arbiter_if.slave (triggers, local request, status)
//
// Build option: define COUNTER_ARB_SAT_EN to saturate count at 0 and at
// all-ones instead of wrapping; a saturated op still consumes its request.
module counter_arbiter #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned PEND_W = 4
) (
   input logic                clk1,
   input logic                reset,
   counter_arbiter_if.slave   bus
);

   typedef enum logic {StIdle, StExec} state_e;
   typedef enum logic [1:0] {SrcUp = 2'd0, SrcDown = 2'd1, SrcLoc = 2'd2} src_e;

   state_e            state_q, state_d;
   src_e              grant_q, grant_d;
   src_e              ptr_q, ptr_d;     // highest-priority source for the next search
   logic [WIDTH-1:0]  count_q, count_d;
   logic [PEND_W-1:0] pend_up_q, pend_up_d;
   logic [PEND_W-1:0] pend_down_q, pend_down_d;
   logic              overflow_q, overflow_d;

   logic [2:0]        elig;
   src_e              cand0, cand1, cand2, win;
   logic              win_valid;
   logic              dec_up, dec_down;
   logic [PEND_W:0]   up_nxt, down_nxt;

   function automatic src_e next_src(input src_e s);
      case (s)
         SrcUp:   return SrcDown;
         SrcDown: return SrcLoc;
         default: return SrcUp;
      endcase
   endfunction

   function automatic logic [WIDTH-1:0] cnt_up(input logic [WIDTH-1:0] c);
`ifdef COUNTER_ARB_SAT_EN
      return (c == {WIDTH{1'b1}}) ? c : c + WIDTH'(1);
`else
      return c + WIDTH'(1);
`endif
   endfunction

   function automatic logic [WIDTH-1:0] cnt_down(input logic [WIDTH-1:0] c);
`ifdef COUNTER_ARB_SAT_EN
      return (c == '0) ? c : c - WIDTH'(1);
`else
      return c - WIDTH'(1);
`endif
   endfunction

   // Returns {dropped, next value}. A trigger that meets a same-cycle drain
   // cancels out, so it is never dropped even when the counter is full.
   function automatic logic [PEND_W:0] pend_next(input logic [PEND_W-1:0] p,
                                                 input logic inc, input logic dec);
      logic              drop;
      logic [PEND_W-1:0] v;
      drop = 1'b0;
      v    = p;
      if (inc && !dec) begin
         if (p == {PEND_W{1'b1}}) drop = 1'b1;
         else                     v = p + PEND_W'(1);
      end else if (!inc && dec) begin
         v = p - PEND_W'(1);
      end
      return {drop, v};
   endfunction

   // Round-robin search starting at ptr_q.
   always_comb begin
      elig          = '0;
      elig[SrcUp]   = (pend_up_q != '0);
      elig[SrcDown] = (pend_down_q != '0);
      elig[SrcLoc]  = bus.loc_req;
      cand0         = ptr_q;
      cand1         = next_src(cand0);
      cand2         = next_src(cand1);
      win           = cand0;
      win_valid     = 1'b1;
      if (elig[cand0])      win = cand0;
      else if (elig[cand1]) win = cand1;
      else if (elig[cand2]) win = cand2;
      else                  win_valid = 1'b0;
   end

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      ptr_d      = ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      dec_up     = 1'b0;
      dec_down   = 1'b0;

      case (state_q)
         StIdle: begin
            if (win_valid) begin
               grant_d = win;
               state_d = StExec;
            end
         end
         default: begin
            case (grant_q)
               SrcUp: begin
                  count_d = cnt_up(count_q);
                  dec_up  = 1'b1;
               end
               SrcDown: begin
                  count_d  = cnt_down(count_q);
                  dec_down = 1'b1;
               end
               default: begin
                  case (bus.loc_op)
                     2'b01:   count_d = cnt_up(count_q);
                     2'b10:   count_d = cnt_down(count_q);
                     2'b11:   count_d = '0;
                     default: count_d = count_q;
                  endcase
               end
            endcase
            ptr_d   = next_src(grant_q);
            state_d = StIdle;
         end
      endcase

      up_nxt      = pend_next(pend_up_q, bus.trig_up, dec_up);
      down_nxt    = pend_next(pend_down_q, bus.trig_down, dec_down);
      pend_up_d   = up_nxt[PEND_W-1:0];
      pend_down_d = down_nxt[PEND_W-1:0];
      if (up_nxt[PEND_W] || down_nxt[PEND_W]) overflow_d = 1'b1;

      // Host clear wins over everything in its cycle, including new triggers.
      if (bus.trig_reset) begin
         state_d     = StIdle;
         grant_d     = SrcUp;
         ptr_d       = SrcUp;
         count_d     = '0;
         pend_up_d   = '0;
         pend_down_d = '0;
         overflow_d  = 1'b0;
      end
   end

   always_ff @(posedge clk1) begin
      if (reset) begin
         state_q     <= StIdle;
         grant_q     <= SrcUp;
         ptr_q       <= SrcUp;
         count_q     <= '0;
         pend_up_q   <= '0;
         pend_down_q <= '0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         ptr_q       <= ptr_d;
         count_q     <= count_d;
         pend_up_q   <= pend_up_d;
         pend_down_q <= pend_down_d;
         overflow_q  <= overflow_d;
      end
   end

   // Ack is driven during the EXEC cycle so the requester can drop loc_req on
   // the same edge that applies the op; otherwise IDLE would re-grant it.
   assign bus.loc_ack   = (state_q == StExec) && (grant_q == SrcLoc) &&
                          !reset && !bus.trig_reset;
   assign bus.count     = count_q;
   assign bus.pend_up   = pend_up_q;
   assign bus.pend_down = pend_down_q;
   assign bus.overflow  = overflow_q;
   assign bus.busy      = (state_q == StExec) || (pend_up_q != '0) ||
                          (pend_down_q != '0) || bus.loc_req;

endmodule
